// File: rtl/branch_predictor.sv
// Bimodal conditional-branch predictor: 2**IDX_W two-bit saturating counters,
// zero-latency Fetch lookup, Memory-stage training, and lookup/mispredict stats.
module bp_ctr #(
  parameter logic [1:0] INIT = 2'b10
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we,
  input  logic       cnd,
  output logic [1:0] state
);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      state <= INIT;
    else if (we) begin
      if (cnd) begin
        if (state != 2'b11) state <= state + 2'd1;
      end else begin
        if (state != 2'b00) state <= state - 2'd1;
      end
    end
  end
endmodule

module branch_predictor #(
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = 2'b10,
  parameter int         CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       f_icode_i,
  input  logic [3:0]       f_ifun_i,
  input  logic [63:0]      f_PC_i,
  input  logic             F_stall_i,
  output logic             f_branch_taken_o,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       M_ifun_i,
  input  logic [63:0]      M_PC_i,
  input  logic             M_Cnd_i,
  input  logic             M_branch_taken_i,
  input  logic             M_bubble_i,
  output logic             m_mispredict_o,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);
  localparam int         NUM_ENT = 1 << IDX_W;
  localparam logic [3:0] IJXX    = 4'h7;

  logic [NUM_ENT-1:0][1:0] tbl;
  logic [IDX_W-1:0]        f_idx, m_idx;
  logic                    upd, train, lookup_inc;
  logic                    unused_pc_hi;

  assign f_idx        = f_PC_i[IDX_W-1:0];
  assign m_idx        = M_PC_i[IDX_W-1:0];
  assign unused_pc_hi = ^{f_PC_i[63:IDX_W], M_PC_i[63:IDX_W]};

  assign upd            = (M_icode_i == IJXX) && !M_bubble_i;
  assign train          = upd && (M_ifun_i != 4'h0);
  assign m_mispredict_o = upd && (M_Cnd_i ^ M_branch_taken_i);
  assign lookup_inc     = (f_icode_i == IJXX) && (f_ifun_i != 4'h0) && !F_stall_i;

  for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
    bp_ctr #(.INIT(INIT_STATE)) u_ctr (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .we      (train && (m_idx == IDX_W'(g))),
      .cnd     (M_Cnd_i),
      .state   (tbl[g])
    );
  end

  // Lookup reads the pre-edge table; a same-cycle update to the same entry is not bypassed.
  always_comb begin
    f_branch_taken_o = 1'b0;
    if (f_icode_i == IJXX)
      f_branch_taken_o = (f_ifun_i == 4'h0) ? 1'b1 : tbl[f_idx][1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lookup_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (lookup_inc && (lookup_cnt_o != '1))
        lookup_cnt_o <= lookup_cnt_o + CNT_W'(1);
      if (m_mispredict_o && (mispred_cnt_o != '1))
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (CNT_W=4 so counter saturation is reachable).
module tb_branch_predictor;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       f_icode, f_ifun, m_icode, m_ifun;
  logic [63:0]      f_pc, m_pc;
  logic             f_stall, m_cnd, m_pred, m_bub;
  logic             f_taken, m_mis;
  logic [CNT_W-1:0] lcnt, mcnt;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(6), .INIT_STATE(2'b10), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .f_icode_i        (f_icode),
    .f_ifun_i         (f_ifun),
    .f_PC_i           (f_pc),
    .F_stall_i        (f_stall),
    .f_branch_taken_o (f_taken),
    .M_icode_i        (m_icode),
    .M_ifun_i         (m_ifun),
    .M_PC_i           (m_pc),
    .M_Cnd_i          (m_cnd),
    .M_branch_taken_i (m_pred),
    .M_bubble_i       (m_bub),
    .m_mispredict_o   (m_mis),
    .lookup_cnt_o     (lcnt),
    .mispred_cnt_o    (mcnt)
  );

  // sel: 0 = f_branch_taken_o, 1 = m_mispredict_o, 2 = lookup_cnt_o, 3 = mispred_cnt_o
  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  // Monitor: outputs are settled mid-cycle; drain every expectation queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0:       act = {31'b0, f_taken};
        1:       act = {31'b0, m_mis};
        2:       act = {28'b0, lcnt};
        default: act = {28'b0, mcnt};
      endcase
      nvec++;
      if (act !== e.v) begin
        nmis++;
        $display("FAIL %s: got %0h expected %0h", e.nm, act, e.v);
      end
    end
  end

  task automatic ex(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.sel = sel; e.v = v;
    sb.push_back(e);
  endtask

  // Advance one cycle and return all inputs to idle (no jXX in F or M).
  task automatic nxt();
    @(posedge clk); #1;
    f_icode = 4'h1; f_ifun = 4'h0; f_pc = 64'h0; f_stall = 1'b1;
    m_icode = 4'h1; m_ifun = 4'h0; m_pc = 64'h0;
    m_cnd = 1'b0; m_pred = 1'b0; m_bub = 1'b1;
  endtask

  task automatic fl(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] pc, input logic st);
    f_icode = ic; f_ifun = fn; f_pc = pc; f_stall = st;
  endtask

  task automatic ml(input logic [3:0] fn, input logic [63:0] pc, input logic cnd, input logic pred,
                    input logic bub);
    m_icode = 4'h7; m_ifun = fn; m_pc = pc; m_cnd = cnd; m_pred = pred; m_bub = bub;
  endtask

  initial begin
    rst_n = 1'b0;
    f_icode = 4'h1; f_ifun = 4'h0; f_pc = 64'h0; f_stall = 1'b1;
    m_icode = 4'h1; m_ifun = 4'h0; m_pc = 64'h0;
    m_cnd = 1'b0; m_pred = 1'b0; m_bub = 1'b1;
    nxt();
    // A: held in reset, lookup at 0x40 sees INIT (weakly taken)
    nxt(); fl(4'h7, 4'h1, 64'h40, 1'b0);
    ex("rst_taken", 0, 1); ex("rst_lcnt", 2, 0); ex("rst_mcnt", 3, 0);
    // B: out of reset; the lookup during reset was not counted
    nxt(); rst_n = 1'b1; fl(4'h7, 4'h1, 64'h40, 1'b0);
    ex("b_taken", 0, 1); ex("b_lcnt", 2, 0);
    // C/D: two not-taken trainings at 0x40, both mispredicted
    nxt(); ml(4'h1, 64'h40, 1'b0, 1'b1, 1'b0);
    ex("c_lcnt", 2, 1); ex("c_mis", 1, 1); ex("c_mcnt", 3, 0);
    nxt(); ml(4'h1, 64'h40, 1'b0, 1'b1, 1'b0); fl(4'h7, 4'h1, 64'h40, 1'b1);
    ex("d_mis", 1, 1); ex("d_taken_01", 0, 0); ex("d_mcnt", 3, 1);
    nxt(); fl(4'h7, 4'h2, 64'h40, 1'b0);
    ex("e_taken_00", 0, 0); ex("e_mcnt", 3, 2); ex("e_lcnt_stall", 2, 1);
    // F..J: five taken trainings at 0x13 (correctly predicted)
    for (int i = 0; i < 5; i++) begin
      nxt(); ml(4'h1, 64'h13, 1'b1, 1'b1, 1'b0);
      if (i == 0) begin ex("f_lcnt", 2, 2); ex("f_mis0", 1, 0); end
    end
    fl(4'h7, 4'h1, 64'h13, 1'b1);
    ex("sat_taken", 0, 1);
    // K: one not-taken; alias 0x53 still sees the old 11
    nxt(); ml(4'h1, 64'h13, 1'b0, 1'b1, 1'b0); fl(4'h7, 4'h1, 64'h53, 1'b1);
    ex("k_mis", 1, 1); ex("k_alias_taken", 0, 1);
    nxt(); fl(4'h7, 4'h1, 64'h13, 1'b1);
    ex("l_taken_10", 0, 1); ex("l_mcnt", 3, 3);
    // M/N: a second not-taken proves the entry was 10, not stuck at 11
    nxt(); ml(4'h1, 64'h13, 1'b0, 1'b1, 1'b0);
    nxt(); fl(4'h7, 4'h1, 64'h13, 1'b1);
    ex("n_taken_01", 0, 0); ex("n_mcnt", 3, 4);
    // O/P/Q: same-index collision, entry 0x05 = 01, lookup via 0x45
    nxt(); ml(4'h1, 64'h05, 1'b0, 1'b0, 1'b0);
    ex("o_mis0", 1, 0);
    nxt(); ml(4'h1, 64'h05, 1'b1, 1'b0, 1'b0); fl(4'h7, 4'h1, 64'h45, 1'b1);
    ex("p_coll_old", 0, 0); ex("p_mis", 1, 1);
    nxt(); fl(4'h7, 4'h1, 64'h45, 1'b1);
    ex("q_coll_new", 0, 1); ex("q_mcnt", 3, 5);
    // R/S: bubble suppresses training and mispredict
    nxt(); ml(4'h1, 64'h05, 1'b0, 1'b1, 1'b1);
    ex("r_bub_mis", 1, 0);
    nxt(); fl(4'h7, 4'h1, 64'h05, 1'b1);
    ex("s_bub_notrain", 0, 1); ex("s_mcnt", 3, 5);
    // T/U: unconditional jmp flags mispredict but does not train
    nxt(); ml(4'h0, 64'h05, 1'b0, 1'b1, 1'b0);
    ex("t_jmp_mis", 1, 1);
    nxt(); fl(4'h7, 4'h1, 64'h05, 1'b1);
    ex("u_jmp_notrain", 0, 1); ex("u_mcnt", 3, 6);
    // V/W: jmp always taken (entry 0x40 is 00); non-jXX never taken; neither counted
    nxt(); fl(4'h7, 4'h0, 64'h40, 1'b0);
    ex("v_jmp_taken", 0, 1);
    nxt(); fl(4'h6, 4'h1, 64'h05, 1'b0);
    ex("w_nonj_taken", 0, 0);
    // X: reset asserted; combinational lookup still reads trained 00
    nxt(); rst_n = 1'b0; fl(4'h7, 4'h1, 64'h40, 1'b0);
    ex("x_lcnt", 2, 2); ex("x_taken_pre", 0, 0);
    nxt(); rst_n = 1'b1; fl(4'h7, 4'h1, 64'h40, 1'b1);
    ex("y_taken_init", 0, 1); ex("y_lcnt0", 2, 0); ex("y_mcnt0", 3, 0);
    nxt(); fl(4'h7, 4'h1, 64'h13, 1'b1);
    ex("z_taken_init", 0, 1);
    // 20 mispredicts with unstalled lookups: both counters saturate at 4'hF
    for (int i = 0; i < 20; i++) begin
      nxt(); ml(4'h1, 64'h20, 1'b0, 1'b1, 1'b0); fl(4'h7, 4'h1, 64'h40, 1'b0);
      ex("sat_mis", 1, 1);
    end
    nxt();
    ex("mcnt_sat", 3, 4'hF); ex("lcnt_sat", 2, 4'hF);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic conditional-branch predictor for the y86 pipeline.
- Holds a direct-mapped table of 2-bit saturating counters indexed by low PC bits.
- Supplies the Fetch-stage taken/not-taken prediction (f_branch_taken_o), which travels down the pipe as M_branch_taken.
- Trains the table when a jXX resolves in Memory, and keeps lookup/misprediction statistics.
- Replaces the static always-taken prediction in front of PC selection.

Parameters:
- IDX_W, 6, index width; table has 2**IDX_W entries, index = PC[IDX_W-1:0].
- INIT_STATE, 2'b10, counter value loaded at reset (10 = weakly taken).
- CNT_W, 32, width of each statistics counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- f_icode_i  in  4  icode of the instruction in Fetch.
- f_ifun_i  in  4  ifun of the instruction in Fetch.
- f_PC_i  in  64  PC of the instruction in Fetch.
- F_stall_i  in  1  Fetch stalled this cycle; suppresses lookup counting.
- f_branch_taken_o  out  1  prediction for the current Fetch instruction.
- M_icode_i  in  4  icode in Memory stage.
- M_ifun_i  in  4  ifun in Memory stage.
- M_PC_i  in  64  PC of the Memory-stage instruction (carried down the pipe).
- M_Cnd_i  in  1  resolved condition of the Memory-stage jXX.
- M_branch_taken_i  in  1  prediction that was made for it in Fetch.
- M_bubble_i  in  1  Memory stage holds a bubble; no training.
- m_mispredict_o  out  1  Memory-stage jXX was mispredicted.
- lookup_cnt_o  out  CNT_W  conditional-jump lookups counted.
- mispred_cnt_o  out  CNT_W  mispredictions counted.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - every table entry = INIT_STATE.
  - lookup_cnt_o = 0, mispred_cnt_o = 0.
  - Reset overrides any same-cycle update. Reset mid-operation discards all training.
- Lookup (combinational, zero latency):
  - Applies when f_icode_i == IJXX (4'h7).
  - ifun == 0 (jmp) -> f_branch_taken_o = 1.
  - Otherwise f_branch_taken_o = table[f_PC_i[IDX_W-1:0]][1].
  - Non-jXX -> f_branch_taken_o = 0.
  - During reset the output reflects the table contents being read, which equal INIT_STATE after the reset edge.
- Misprediction flag (combinational):
  - upd = (M_icode_i == IJXX) && !M_bubble_i.
  - m_mispredict_o = upd && (M_Cnd_i ^ M_branch_taken_i).
- Training: on the clock edge when upd && M_ifun_i != 0, entry e = table[M_PC_i[IDX_W-1:0]] becomes:
  - M_Cnd_i = 1: e == 2'b11 ? 2'b11 : e + 1.
  - M_Cnd_i = 0: e == 2'b00 ? 2'b00 : e - 1.
  - Unconditional jmp does not train.
- Simultaneous lookup and update to the same index:
  - The lookup sees the pre-edge (old) value. No bypass.
  - The update lands at the edge.
  - Aliasing between PCs with equal low bits is permitted and not detected.
- Statistics:
  - lookup_cnt_o increments when f_icode_i == IJXX && f_ifun_i != 0 && !F_stall_i.
  - mispred_cnt_o increments when m_mispredict_o is high.
  - Both saturate at all-ones and do not wrap.
  - The two counters are independent; both may increment in the same cycle.
- Only the low IDX_W bits of either PC are used.
- No multi-cycle state beyond the table and the counters.

Test Plan:
- Reset then lookup: f_icode=7, f_ifun=1, f_PC=0x40 -> f_branch_taken_o = 1 (INIT 10). lookup_cnt = 1 after one unstalled cycle.
- Train not-taken: two M updates at M_PC=0x40 with Cnd=0 and M_branch_taken=1.
  - m_mispredict_o = 1 on both cycles.
  - Entry goes 10->01->00.
  - Lookup at 0x40 -> 0; mispred_cnt = 2.
- Saturation: four Cnd=1 updates on PC 0x13 -> entry 11. A fifth leaves it 11. A single Cnd=0 -> 10, prediction still 1.
- Same-index collision: entry 0x05 = 01. Same-cycle lookup PC 0x45 and update PC 0x05 with Cnd=1 -> lookup returns 0. Next cycle returns 1.
- Bubble and jmp filtering:
  - M_bubble=1 with jXX: no training, m_mispredict_o = 0.
  - M_ifun=0 with Cnd^pred = 1: no table change, but m_mispredict_o = 1.
  - f_ifun=0 always predicts 1.
- Mid-run reset and saturation: after training, rst_n_i low for one edge -> all entries 10, counters 0. With CNT_W forced to 4, 20 mispredictions -> mispred_cnt_o = 4'hF.
